// File: rtl/myalu_mdu_if.sv
// Pipeline-side bundle for myalu_mdu: request/response handshakes, flush and status.
interface myalu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] mdu_a;
    logic [WIDTH-1:0] mdu_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mdu_out;
    logic             busy;

    modport master (
        output flush, in_valid, op, mdu_a, mdu_b, out_ready,
        input  in_ready, out_valid, mdu_out, busy
    );

    modport slave (
        input  flush, in_valid, op, mdu_a, mdu_b, out_ready,
        output in_ready, out_valid, mdu_out, busy
    );
endinterface

// File: rtl/myalu_mdu.sv
// RV32M multi-cycle multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional MYALU_MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply finish at accept.
module myalu_mdu #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    myalu_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, out_q;
    logic [2*WIDTH-1:0] acc, acc_nxt, prod;
    logic [CNT_W-1:0]   cnt;

    function automatic logic sign_a(input logic [2:0] o);
        return (o == 3'b001) || (o == 3'b010) || (o == 3'b100) || (o == 3'b110);
    endfunction

    function automatic logic sign_b(input logic [2:0] o);
        return (o == 3'b001) || (o == 3'b100) || (o == 3'b110);
    endfunction

    // {hit, value}: cases whose result is fixed by RISC-V semantics rather than the datapath
    function automatic logic [WIDTH:0] special(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] min_neg;
        min_neg = {1'b1, {(WIDTH-1){1'b0}}};
        special = '0;
        if (o[2]) begin
            if (y == '0)
                special = {1'b1, (o[1] ? x : {WIDTH{1'b1}})};
            else if (!o[0] && x == min_neg && y == {WIDTH{1'b1}})
                special = {1'b1, (o[1] ? {WIDTH{1'b0}} : x)};
        end else if (x == '0 || y == '0) begin
            special = {1'b1, {WIDTH{1'b0}}};
        end
    endfunction

    logic             neg_a, neg_b, in_neg_a, in_neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, in_mag_a, in_mag_b, quo, rmd, res;
    logic [WIDTH:0]   mul_sum, div_trial, div_diff, spec;

    assign neg_a    = sign_a(op_q) & a_q[WIDTH-1];
    assign neg_b    = sign_b(op_q) & b_q[WIDTH-1];
    assign mag_a    = neg_a ? -a_q : a_q;
    assign mag_b    = neg_b ? -b_q : b_q;
    assign in_neg_a = sign_a(bus.op) & bus.mdu_a[WIDTH-1];
    assign in_neg_b = sign_b(bus.op) & bus.mdu_b[WIDTH-1];
    assign in_mag_a = in_neg_a ? -bus.mdu_a : bus.mdu_a;
    assign in_mag_b = in_neg_b ? -bus.mdu_b : bus.mdu_b;

    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign div_trial = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, mag_b};

    always_comb begin
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        if (op_q[2])
            acc_nxt = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    assign prod = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    assign quo  = acc_nxt[WIDTH-1:0];
    assign rmd  = acc_nxt[2*WIDTH-1:WIDTH];
    assign spec = special(op_q, a_q, b_q);

    always_comb begin
        res = '0;
        if (spec[WIDTH]) begin
            res = spec[WIDTH-1:0];
        end else begin
            case (op_q)
                3'b000:                 res = prod[WIDTH-1:0];
                3'b001, 3'b010, 3'b011: res = prod[2*WIDTH-1:WIDTH];
                3'b100, 3'b101:         res = (neg_a ^ neg_b) ? -quo : quo;
                default:                res = neg_a ? -rmd : rmd;
            endcase
        end
    end

`ifdef MYALU_MDU_EARLY_OUT_EN
    logic [WIDTH:0] in_spec;
    assign in_spec = special(bus.op, bus.mdu_a, bus.mdu_b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    op_q  <= bus.op;
                    a_q   <= bus.mdu_a;
                    b_q   <= bus.mdu_b;
                    acc   <= {{WIDTH{1'b0}}, (bus.op[2] ? in_mag_a : in_mag_b)};
                    cnt   <= '0;
                    state <= S_BUSY;
`ifdef MYALU_MDU_EARLY_OUT_EN
                    if (in_spec[WIDTH]) begin
                        out_q <= in_spec[WIDTH-1:0];
                        state <= S_DONE;
                    end
`endif
                end
                S_BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        out_q <= res;
                        state <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.mdu_out   = out_q;
endmodule

// File: tb/tb_myalu_mdu.sv
// Directed bench for myalu_mdu: vector table for results/latency, plus backpressure, flush and reset sequences.
module tb_myalu_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    myalu_mdu_if #(.WIDTH(32)) bus ();
    myalu_mdu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          early;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat_for(input bit early);
`ifdef MYALU_MDU_EARLY_OUT_EN
        return early ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Accept edge counts as edge 1; result must appear at edge lat_exp and drop one edge after.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int lat_exp);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = o; bus.mdu_a = a; bus.mdu_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.mdu_a = ~a; bus.mdu_b = ~b;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " value"}, bus.mdu_out, e);
        chk({nm, " latency"}, lat, lat_exp);
        @(posedge clk); #1;
        chk({nm, " out_valid drop"}, {31'b0, bus.out_valid}, 32'd0);
        chk({nm, " in_ready back"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        bit seen;
        vecs[0]  = '{"MUL 7*-3",        3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"MULH min*min",    3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 1'b0};
        vecs[2]  = '{"MULHU ff*ff",     3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{"MULHSU ff*ff",    3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"MUL x*0",         3'b000, 32'h12345678,   32'd0,        32'd0,        1'b1};
        vecs[5]  = '{"DIV -7/2",        3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{"REM -7/2",        3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{"DIVU 100/7",      3'b101, 32'd100,        32'd7,        32'd14,       1'b0};
        vecs[8]  = '{"REMU 100/7",      3'b111, 32'd100,        32'd7,        32'd2,        1'b0};
        vecs[9]  = '{"DIV 5/0",         3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[10] = '{"REM 5/0",         3'b110, 32'd5,          32'd0,        32'd5,        1'b1};
        vecs[11] = '{"DIV ovf",         3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[12] = '{"REM ovf",         3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[13] = '{"DIVU 5/0",        3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[14] = '{"MULH -1*-1",      3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[15] = '{"REM 7/-2",        3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        1'b0};

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0;
        bus.mdu_a = '0; bus.mdu_b = '0; bus.out_ready = 1'b1;
        #3;
        chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset mdu_out", bus.mdu_out, 32'd0);
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        #10 rst_n = 1'b1;
        #1 chk("in_ready after reset", {31'b0, bus.in_ready}, 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, lat_for(vecs[i].early));

        // Backpressure: result held, new requests ignored until consumed
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'b101; bus.mdu_a = 32'd100; bus.mdu_b = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", lat, 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.op = 3'b000; bus.mdu_a = 32'd3; bus.mdu_b = 32'd3;
            @(posedge clk); #1;
            chk("bp out_valid held", {31'b0, bus.out_valid}, 32'd1);
            chk("bp mdu_out held", bus.mdu_out, 32'd14);
            chk("bp in_ready low", {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("bp release in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("bp release busy", {31'b0, bus.busy}, 32'd0);

        // Flush at iteration 10
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'b000; bus.mdu_a = 32'd3; bus.mdu_b = 32'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush busy", {31'b0, bus.busy}, 32'd0);
        chk("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush no result", {31'b0, seen}, 32'd0);

        // Flush beats accept in IDLE
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'b101; bus.mdu_a = 32'd9; bus.mdu_b = 32'd3;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush blocks accept", {31'b0, bus.busy}, 32'd0);
        run_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'b100; bus.mdu_a = 32'd100; bus.mdu_b = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst mdu_out", bus.mdu_out, 32'd0);
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
        run_op("REMU after rst", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/myalu_mdu.md
Name: myalu_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside myalu in the EX stage. The pipeline stalls on in_ready/out_valid.
- Operand width is generic. Iterative shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshake on both input and output.

Parameters:
WIDTH, 32, operand/result width in bits; legal range >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort of any in-flight operation (pipeline flush).
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request (state IDLE).
op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
mdu_a  input  WIDTH  rs1 operand (multiplicand / dividend).
mdu_b  input  WIDTH  rs2 operand (multiplier / divisor).
out_valid  output  1  result valid.
out_ready  input  1  consumer takes result.
mdu_out  output  WIDTH  result.
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, mdu_out=0, busy=0, counter=0, internal registers 0. in_ready=1 as soon as rst_n deasserts.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - Accept on in_valid&&in_ready at a rising edge. Latch op, mdu_a and mdu_b; input changes after acceptance have no effect.
  - Latch operand signs per op: MULH signs both; MULHSU signs a only; DIV/REM sign both; others unsigned.
  - Load magnitudes and clear the counter. Go to BUSY.
- BUSY: one iteration per cycle; counter increments.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on magnitudes.
  - Divide: restoring; WIDTH-bit partial remainder, quotient shifted in LSB-first from dividend MSB.
  - After WIDTH iterations, go to DONE. At that same edge, register mdu_out with sign correction:
    - MUL: low WIDTH bits of the signed-corrected product.
    - MULH/MULHSU/MULHU: high WIDTH bits.
    - DIV quotient: negated if dividend and divisor signs differ.
    - REM remainder: takes the sign of the dividend.
- DONE: out_valid=1; mdu_out held stable until out_ready. On out_valid&&out_ready, go to IDLE; out_valid drops at the next edge. in_ready is low in DONE (no result/request overlap).
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accept edge (33 for WIDTH=32). Throughput is one op per WIDTH+2 cycles minimum.
- Special cases (exact RISC-V semantics, same latency as the normal path):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM of -2^(WIDTH-1) by -1): DIV gives the dividend; REM gives 0.
- flush: in BUSY or DONE, go to IDLE at the next edge. out_valid goes 0 and the result is discarded. In IDLE, flush has priority over accept (no request accepted that cycle).
- rst_n asserted mid-operation: immediate return to reset values. No result is produced.
- busy = (state != IDLE); purely a decode of state.

Optional Feature:
MYALU_MDU_EARLY_OUT_EN
- Defined: these cases skip BUSY and go IDLE->DONE at the accept edge, so out_valid rises 1 edge after accept:
  - divide by zero;
  - signed divide overflow;
  - multiply with either operand zero.
  Result values are identical to the non-early path.
- Undefined: every op takes WIDTH+1 edges. Special-case logic only selects the result value.

Test Plan:
1. MUL mdu_a=7, mdu_b=0xFFFFFFFD (-3), out_ready=1 -> mdu_out=0xFFFFFFEB; out_valid exactly 33 edges after accept, high 1 cycle; in_ready high next cycle.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x12345678*0 -> 0.
3. DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
   - Latency is 33 edges without the macro and 1 edge with MYALU_MDU_EARLY_OUT_EN.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and mdu_out stable, in_ready=0, new in_valid ignored. Raise out_ready -> accepted, next cycle in_ready=1, out_valid=0.
6. Abort: flush at BUSY iteration 10 -> IDLE next edge, out_valid never asserts; a following DIVU 9/3 returns 3. Repeat with rst_n pulsed low mid-BUSY -> outputs 0 immediately, in_ready=1 after release.
